// File: rtl/l2_backing_memory_pkg.sv
// l2_backing_memory_pkg: shared types and default geometry for the L2 backing memory
package l2_backing_memory_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_MEM_SIZE = 4096;
  localparam int DEF_ROW_SIZE = 256;
  localparam int WORD_IDX_SIZE = $clog2(DEF_MEM_SIZE) - $clog2(DEF_XLEN / 8);
  localparam int ROW_POS = $clog2(DEF_ROW_SIZE);
  typedef enum logic [1:0] {MEM_LOAD, MEM_STORE} memory_operation_e;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} memory_operation_size_e;
  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} l2_mem_state_e;
endpackage

// File: rtl/l2_latency_timer.sv
// l2_latency_timer: down-counter whose done fires on the cycle the count would reach zero
module l2_latency_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          abort_i,
  output logic          done_o
);
  logic [CW-1:0] count_q;
  always_ff @(posedge clk)
    if (reset || abort_i) count_q <= '0;
    else if (load_i) count_q <= load_val_i;
    else if (count_q != '0) count_q <= count_q - 1'b1;
  // a zero load means a one-cycle latency, so done fires alongside the load
  assign done_o = load_i ? (load_val_i == '0) : (count_q == CW'(1));
endmodule

// File: rtl/l2_backing_memory.sv
// l2_backing_memory: read-only word store with open-row hit/miss latency for L1 fills
module l2_backing_memory
  import l2_backing_memory_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int ROW_SIZE = DEF_ROW_SIZE,
  parameter int HIT_LATENCY = 4,
  parameter int MISS_LATENCY = 10,
  parameter logic [MEM_SIZE*8-1:0] INIT_IMAGE = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] l2_address,
  input  logic            l2_access,
  output logic [XLEN-1:0] l2_word,
  output logic            l2_word_valid,
  output logic            l2_error
);
  localparam int AW = $clog2(MEM_SIZE);
  localparam int OFF = $clog2(XLEN / 8);
  localparam int IDX_W = AW - OFF;
  localparam int ROW_LSB = $clog2(ROW_SIZE);
  localparam int ROW_W = XLEN - ROW_LSB;
  localparam int CW = $clog2(MISS_LATENCY) + 1;

  l2_mem_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ROW_W-1:0] row_q, row_d, open_row_q;
  logic             oor_q, oor_d, open_row_valid_q;
  logic [XLEN-1:0]  word_q;
  logic             valid_q, err_q;
  logic             accept, hit, abort, done;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^l2_address[OFF-1:0];
  assign accept = state_q == IDLE && l2_access;
  assign abort = state_q == BUSY && !l2_access;
  assign idx_d = accept ? l2_address[AW-1:OFF] : idx_q;
  assign row_d = accept ? l2_address[XLEN-1:ROW_LSB] : row_q;
  assign oor_d = accept ? |l2_address[XLEN-1:AW] : oor_q;
  // out-of-range rows are never opened, so they always miss here
  assign hit = open_row_valid_q && open_row_q == l2_address[XLEN-1:ROW_LSB];

  l2_latency_timer #(.CW(CW)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .load_val_i(hit ? CW'(HIT_LATENCY - 1) : CW'(MISS_LATENCY - 1)),
    .abort_i   (abort),
    .done_o    (done)
  );

  always_comb begin
    state_d = state_q == RESPOND ? IDLE :
              state_q == BUSY    ? (!l2_access ? IDLE : done ? RESPOND : BUSY) :
              l2_access          ? (done ? RESPOND : BUSY) : IDLE;
  end

  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      row_q <= '0;
      oor_q <= 1'b0;
      open_row_q <= '0;
      open_row_valid_q <= 1'b0;
      word_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      row_q <= row_d;
      oor_q <= oor_d;
      valid_q <= state_d == RESPOND;
      err_q <= state_d == RESPOND && oor_d;
      if (state_d == RESPOND) word_q <= oor_d ? '0 : INIT_IMAGE[idx_d*XLEN +: XLEN];
      if (state_q == RESPOND && !oor_q) begin
        open_row_q <= row_q;
        open_row_valid_q <= 1'b1;
      end
    end

  assign l2_word = word_q;
  assign l2_word_valid = valid_q;
  assign l2_error = err_q;
endmodule
